conn_box_cfg: RTL

//  Parametrised connection box: routes BLE outputs, routing tracks and switch-box lines under a

---
 rtl/conn_box_cfg.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/conn_box_cfg.sv
// Connection box with a serially loaded, double-buffered routing configuration.
// The routing uses only the active copy, so a load in progress never reaches the outputs.
module conn_box_cfg #(
   parameter int W       = 4,
   parameter int S       = 5,
   parameter int REG_OUT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ble_lu_in,
   input  logic         ble_rd_in,
   input  logic [W-1:0] lu_in,
   input  logic [W-1:0] rd_in,
   input  logic [S-1:0] sb_in,
   output logic [W-1:0] lu_out,
   output logic [W-1:0] rd_out,
   output logic [S-1:0] sb_out,
   output logic [S-1:0] sb_oe,
   input  logic         cfg_en,
   input  logic         cfg_in,
   input  logic         cfg_commit,
   output logic         cfg_ready,
   output logic         cfg_err
);
   // state    | meaning
   // ST_EMPTY | shadow count is 0, nothing shifted since reset/commit
   // ST_SHIFT | partial load in progress
   // ST_FULL  | shadow holds CFG_BITS bits, waiting for commit
   localparam int CFG_BITS = 4*W + 3*S;
   localparam int CW       = $clog2(CFG_BITS + 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_FULL} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic                err_q, err_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_EMPTY;
         cnt_q    <= '0;
         shadow_q <= '0;
         active_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      err_d    = err_q;
      case (state_q)
         ST_EMPTY, ST_SHIFT: begin
            if (cfg_commit) err_d = 1'b1;
            if (cfg_en) begin
               shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
               cnt_d    = cnt_q + CW'(1);
               state_d  = (cnt_q == CW'(CFG_BITS - 1)) ? ST_FULL : ST_SHIFT;
            end
         end
         ST_FULL: begin
            // Commit has priority; a simultaneous shift bit is dropped and flagged.
            if (cfg_commit) begin
               active_d = shadow_q;
               cnt_d    = '0;
               state_d  = ST_EMPTY;
            end
            if (cfg_en) err_d = 1'b1;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   assign cfg_ready = (state_q == ST_FULL);
   assign cfg_err   = err_q;

   logic [W-1:0] lu_c, rd_c;
   logic [S-1:0] sb_c, oe_c;

   always_comb begin
      lu_c = '0;
      rd_c = '0;
      sb_c = '0;
      oe_c = '0;
      for (int t = 0; t < W; t++) begin
         case (active_q[2*t +: 2])
            2'b01:   lu_c[t] = lu_in[t];
            2'b10:   lu_c[t] = ble_lu_in;
            2'b11:   lu_c[t] = sb_in[t % S];
            default: lu_c[t] = 1'b0;
         endcase
         case (active_q[2*W + 2*t +: 2])
            2'b01:   rd_c[t] = rd_in[t];
            2'b10:   rd_c[t] = ble_rd_in;
            2'b11:   rd_c[t] = sb_in[t % S];
            default: rd_c[t] = 1'b0;
         endcase
      end
      for (int s = 0; s < S; s++) begin
         oe_c[s] = active_q[4*W + 3*s + 2];
         case (active_q[4*W + 3*s +: 2])
            2'b00:   sb_c[s] = ble_lu_in;
            2'b01:   sb_c[s] = ble_rd_in;
            2'b10:   sb_c[s] = lu_in[s % W];
            default: sb_c[s] = rd_in[s % W];
         endcase
         sb_c[s] = sb_c[s] & oe_c[s];
      end
   end

   generate
      if (REG_OUT != 0) begin : g_reg_out
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               lu_out <= '0;
               rd_out <= '0;
               sb_out <= '0;
               sb_oe  <= '0;
            end else begin
               lu_out <= lu_c;
               rd_out <= rd_c;
               sb_out <= sb_c;
               sb_oe  <= oe_c;
            end
         end
      end else begin : g_comb_out
         assign lu_out = lu_c;
         assign rd_out = rd_c;
         assign sb_out = sb_c;
         assign sb_oe  = oe_c;
      end
   endgenerate
endmodule
